// File: rtl/axis_demux_pkt_if.sv
// Stream bundle for the packet-aware demux: one slave stream in, PORT_NUM
// master streams out, plus the drop pulse and saturating drop counter.
interface axis_demux_pkt_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PORT_NUM   = 4,
  parameter int CNT_WIDTH  = 16
);

  logic [PORT_NUM-1:0]            demux_ctrl_i;
  logic [DATA_WIDTH-1:0]          s_axi_dat_i;
  logic                           s_axi_lst_i;
  logic                           s_axi_vld_i;
  logic                           s_axi_rdy_o;
  logic [DATA_WIDTH*PORT_NUM-1:0] m_axi_dat_o;
  logic [PORT_NUM-1:0]            m_axi_lst_o;
  logic [PORT_NUM-1:0]            m_axi_vld_o;
  logic [PORT_NUM-1:0]            m_axi_rdy_i;
  logic                           drop_o;
  logic [CNT_WIDTH-1:0]           drop_cnt_o;

  // Demux side: consumes the slave stream and master readies.
  modport slave (
    input  demux_ctrl_i, s_axi_dat_i, s_axi_lst_i, s_axi_vld_i, m_axi_rdy_i,
    output s_axi_rdy_o, m_axi_dat_o, m_axi_lst_o, m_axi_vld_o, drop_o, drop_cnt_o
  );

  // Environment side: drives the slave stream and master readies.
  modport master (
    output demux_ctrl_i, s_axi_dat_i, s_axi_lst_i, s_axi_vld_i, m_axi_rdy_i,
    input  s_axi_rdy_o, m_axi_dat_o, m_axi_lst_o, m_axi_vld_o, drop_o, drop_cnt_o
  );

endinterface

// File: rtl/axis_demux_pkt.sv
// Packet-aware registered 1-to-N AXI-stream demux.
// The route is latched on a packet's first beat and held until its last beat.
// Packets whose first-beat select is not one-hot are swallowed and counted.
// A main + skid buffer gives a registered s_axi_rdy_o at full throughput.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a first beat; select is evaluated on accept
// ST_PASS | inside a legal packet; beats follow route_q
// ST_DROP | inside an illegal packet; beats are accepted and discarded
module axis_demux_pkt #(
  parameter int DATA_WIDTH = 8,
  parameter int PORT_NUM   = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  axis_demux_pkt_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t state_q;
  state_t state_d;

  logic [PORT_NUM-1:0]   route_q;

  logic                  main_vld;
  logic [DATA_WIDTH-1:0] main_dat;
  logic                  main_lst;
  logic [PORT_NUM-1:0]   main_route;

  logic                  skid_vld;
  logic [DATA_WIDTH-1:0] skid_dat;
  logic                  skid_lst;
  logic [PORT_NUM-1:0]   skid_route;

  logic                  drop_q;
  logic [CNT_WIDTH-1:0]  drop_cnt_q;

  logic                  s_rdy;
  logic                  acc;
  logic                  sel_legal;
  logic                  pop;

  logic                  wr_en;
  logic [PORT_NUM-1:0]   wr_route;
  logic                  drop_evt;

  // Ready only depends on the skid flop, never on downstream ready.
  assign s_rdy     = ~skid_vld;
  assign acc       = bus.s_axi_vld_i & s_rdy;
  assign sel_legal = $onehot(bus.demux_ctrl_i);
  assign pop       = main_vld & (|(main_route & bus.m_axi_rdy_i));

  // Packet state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: first beat picks PASS/DROP unless it is also the last beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (acc && !bus.s_axi_lst_i) begin
          state_d = sel_legal ? ST_PASS : ST_DROP;
        end
      end
      ST_PASS, ST_DROP: begin
        if (acc && bus.s_axi_lst_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-beat decisions: write to buffer with which route, or flag a drop.
  always_comb begin
    wr_en    = 1'b0;
    wr_route = route_q;
    drop_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (acc) begin
          if (sel_legal) begin
            wr_en    = 1'b1;
            wr_route = bus.demux_ctrl_i;
          end else begin
            drop_evt = 1'b1;
          end
        end
      end
      ST_PASS: begin
        wr_en = acc;
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

  // Latch the route on the first beat of a legal packet.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      route_q <= '0;
    end else if (state_q == ST_IDLE && acc && sel_legal) begin
      route_q <= bus.demux_ctrl_i;
    end
  end

  // Main/skid buffer. A write with a full skid cannot occur because ready
  // is low whenever skid holds a beat, so the skid-to-main refill never
  // collides with an incoming beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_vld   <= 1'b0;
      main_dat   <= '0;
      main_lst   <= 1'b0;
      main_route <= '0;
      skid_vld   <= 1'b0;
      skid_dat   <= '0;
      skid_lst   <= 1'b0;
      skid_route <= '0;
    end else if (pop) begin
      if (skid_vld) begin
        main_vld   <= 1'b1;
        main_dat   <= skid_dat;
        main_lst   <= skid_lst;
        main_route <= skid_route;
        skid_vld   <= 1'b0;
      end else if (wr_en) begin
        main_vld   <= 1'b1;
        main_dat   <= bus.s_axi_dat_i;
        main_lst   <= bus.s_axi_lst_i;
        main_route <= wr_route;
      end else begin
        main_vld   <= 1'b0;
      end
    end else if (wr_en) begin
      if (!main_vld) begin
        main_vld   <= 1'b1;
        main_dat   <= bus.s_axi_dat_i;
        main_lst   <= bus.s_axi_lst_i;
        main_route <= wr_route;
      end else begin
        skid_vld   <= 1'b1;
        skid_dat   <= bus.s_axi_dat_i;
        skid_lst   <= bus.s_axi_lst_i;
        skid_route <= wr_route;
      end
    end
  end

  // Drop pulse one cycle after the illegal first beat; counter saturates.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      drop_q <= drop_evt;
      if (drop_evt && drop_cnt_q != CNT_MAX) begin
        drop_cnt_q <= drop_cnt_q + CNT_ONE;
      end
    end
  end

  assign bus.s_axi_rdy_o = s_rdy;
  assign bus.m_axi_dat_o = {PORT_NUM{main_dat}};
  assign bus.m_axi_lst_o = {PORT_NUM{main_lst}};
  assign bus.m_axi_vld_o = main_vld ? main_route : '0;
  assign bus.drop_o      = drop_q;
  assign bus.drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_axis_demux_pkt.sv
// Directed bench for axis_demux_pkt: routing, route hold, backpressure,
// illegal selects, counter saturation and asynchronous reset.
module tb_axis_demux_pkt;

  localparam int DW = 8;
  localparam int PN = 4;
  localparam int CW = 2;

  logic clk;
  logic rst;

  int vectors;
  int miscompares;

  axis_demux_pkt_if #(.DATA_WIDTH(DW), .PORT_NUM(PN), .CNT_WIDTH(CW)) bus ();

  axis_demux_pkt #(.DATA_WIDTH(DW), .PORT_NUM(PN), .CNT_WIDTH(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l,
                       input logic [3:0] c);
    bus.s_axi_vld_i  = v;
    bus.s_axi_dat_i  = d;
    bus.s_axi_lst_i  = l;
    bus.demux_ctrl_i = c;
  endtask

  function automatic logic [7:0] port_dat(input int p);
    return bus.m_axi_dat_o[p*DW +: DW];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 4'b0000);
    bus.m_axi_rdy_i = 4'b1111;
    #12;
    vectors++;
    if (bus.m_axi_vld_o !== 4'b0000) begin
      miscompares++; $display("FAIL reset_vld got=%b exp=0000", bus.m_axi_vld_o);
    end
    vectors++;
    if (bus.s_axi_rdy_o !== 1'b1) begin
      miscompares++; $display("FAIL reset_rdy got=%b exp=1", bus.s_axi_rdy_o);
    end
    vectors++;
    if (bus.drop_o !== 1'b0 || bus.drop_cnt_o !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_drop got=%b/%0d exp=0/0", bus.drop_o, bus.drop_cnt_o);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_route();
    logic [7:0] d [3];
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, d[i], (i == 2), 4'b0100);
      step();
      vectors++;
      if (bus.m_axi_vld_o !== 4'b0100 || port_dat(2) !== d[i] ||
          bus.m_axi_lst_o[2] !== (i == 2)) begin
        miscompares++;
        $display("FAIL route_beat%0d got vld=%b dat=%h lst=%b exp vld=0100 dat=%h lst=%0d",
                 i, bus.m_axi_vld_o, port_dat(2), bus.m_axi_lst_o[2], d[i], (i == 2));
      end
    end
    drive(1'b0, 8'h00, 1'b0, 4'b0000);
    step();
    vectors++;
    if (bus.m_axi_vld_o !== 4'b0000) begin
      miscompares++; $display("FAIL route_idle got=%b exp=0000", bus.m_axi_vld_o);
    end
  endtask

  task automatic test_select_change();
    logic [7:0] d [4];
    d[0] = 8'hA1; d[1] = 8'hA2; d[2] = 8'hA3; d[3] = 8'hA4;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, d[i], (i == 3), (i == 0) ? 4'b0001 : 4'b1000);
      step();
      vectors++;
      if (bus.m_axi_vld_o !== 4'b0001 || port_dat(0) !== d[i]) begin
        miscompares++;
        $display("FAIL hold_beat%0d got vld=%b dat=%h exp vld=0001 dat=%h",
                 i, bus.m_axi_vld_o, port_dat(0), d[i]);
      end
    end
    // Next packet starts on the very next cycle with a new route.
    drive(1'b1, 8'h55, 1'b1, 4'b1000);
    step();
    vectors++;
    if (bus.m_axi_vld_o !== 4'b1000 || port_dat(3) !== 8'h55 || bus.m_axi_lst_o[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL back_to_back got vld=%b dat=%h lst=%b exp vld=1000 dat=55 lst=1",
               bus.m_axi_vld_o, port_dat(3), bus.m_axi_lst_o[3]);
    end
    drive(1'b0, 8'h00, 1'b0, 4'b0000);
    step();
  endtask

  task automatic test_backpressure();
    logic [7:0] d [4];
    int si;
    int got;
    logic acc_now;
    d[0] = 8'hB0; d[1] = 8'hB1; d[2] = 8'hB2; d[3] = 8'hB3;
    si  = 0;
    got = 0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      bus.m_axi_rdy_i = (cyc < 5) ? 4'b1101 : 4'b1111;
      if (si < 4) drive(1'b1, d[si], (si == 3), 4'b0010);
      else        drive(1'b0, 8'h00, 1'b0, 4'b0000);
      acc_now = bus.s_axi_vld_i & bus.s_axi_rdy_o;
      if (bus.m_axi_vld_o[1] && bus.m_axi_rdy_i[1]) begin
        vectors++;
        if (bus.m_axi_vld_o !== 4'b0010 || port_dat(1) !== d[got] ||
            bus.m_axi_lst_o[1] !== (got == 3)) begin
          miscompares++;
          $display("FAIL bp_order%0d got vld=%b dat=%h lst=%b exp vld=0010 dat=%h lst=%0d",
                   got, bus.m_axi_vld_o, port_dat(1), bus.m_axi_lst_o[1], d[got], (got == 3));
        end
        got++;
      end
      if (cyc >= 2 && cyc <= 4) begin
        vectors++;
        if (port_dat(1) !== 8'hB0 || bus.m_axi_vld_o !== 4'b0010) begin
          miscompares++;
          $display("FAIL bp_stable got vld=%b dat=%h exp vld=0010 dat=b0",
                   bus.m_axi_vld_o, port_dat(1));
        end
      end
      step();
      if (acc_now) si++;
      if (cyc == 1) begin
        vectors++;
        if (bus.s_axi_rdy_o !== 1'b0) begin
          miscompares++; $display("FAIL bp_rdy_low got=%b exp=0", bus.s_axi_rdy_o);
        end
      end
    end
    vectors++;
    if (got != 4) begin
      miscompares++; $display("FAIL bp_complete got=%0d beats exp=4", got);
    end
    vectors++;
    if (bus.m_axi_vld_o !== 4'b0000 || bus.s_axi_rdy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_drain got vld=%b rdy=%b exp vld=0000 rdy=1",
               bus.m_axi_vld_o, bus.s_axi_rdy_o);
    end
  endtask

  task automatic test_illegal();
    drive(1'b1, 8'hC0, 1'b0, 4'b0000);
    step();
    vectors++;
    if (bus.drop_o !== 1'b1 || bus.m_axi_vld_o !== 4'b0000 || bus.drop_cnt_o !== 2'd1) begin
      miscompares++;
      $display("FAIL drop_first got drop=%b vld=%b cnt=%0d exp drop=1 vld=0000 cnt=1",
               bus.drop_o, bus.m_axi_vld_o, bus.drop_cnt_o);
    end
    // Tail beat of the dropped packet carries a legal select; still discarded.
    drive(1'b1, 8'hC1, 1'b1, 4'b0001);
    step();
    vectors++;
    if (bus.drop_o !== 1'b0 || bus.m_axi_vld_o !== 4'b0000 || bus.drop_cnt_o !== 2'd1) begin
      miscompares++;
      $display("FAIL drop_tail got drop=%b vld=%b cnt=%0d exp drop=0 vld=0000 cnt=1",
               bus.drop_o, bus.m_axi_vld_o, bus.drop_cnt_o);
    end
    drive(1'b1, 8'hC2, 1'b1, 4'b0011);
    step();
    vectors++;
    if (bus.drop_o !== 1'b1 || bus.m_axi_vld_o !== 4'b0000 || bus.drop_cnt_o !== 2'd2) begin
      miscompares++;
      $display("FAIL drop_multi got drop=%b vld=%b cnt=%0d exp drop=1 vld=0000 cnt=2",
               bus.drop_o, bus.m_axi_vld_o, bus.drop_cnt_o);
    end
    drive(1'b1, 8'h77, 1'b1, 4'b0001);
    step();
    vectors++;
    if (bus.drop_o !== 1'b0 || bus.m_axi_vld_o !== 4'b0001 || port_dat(0) !== 8'h77) begin
      miscompares++;
      $display("FAIL drop_recover got drop=%b vld=%b dat=%h exp drop=0 vld=0001 dat=77",
               bus.drop_o, bus.m_axi_vld_o, port_dat(0));
    end
    drive(1'b0, 8'h00, 1'b0, 4'b0000);
    step();
  endtask

  task automatic test_reset_mid_packet();
    drive(1'b1, 8'h91, 1'b0, 4'b0100);
    step();
    drive(1'b1, 8'h92, 1'b0, 4'b0100);
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.m_axi_vld_o !== 4'b0000 || bus.s_axi_rdy_o !== 1'b1 || bus.drop_cnt_o !== 2'd0) begin
      miscompares++;
      $display("FAIL rst_async got vld=%b rdy=%b cnt=%0d exp vld=0000 rdy=1 cnt=0",
               bus.m_axi_vld_o, bus.s_axi_rdy_o, bus.drop_cnt_o);
    end
    step();
    drive(1'b0, 8'h00, 1'b0, 4'b0000);
    rst = 1'b0;
    drive(1'b1, 8'h5A, 1'b1, 4'b0001);
    step();
    vectors++;
    if (bus.m_axi_vld_o !== 4'b0001 || port_dat(0) !== 8'h5A || bus.m_axi_lst_o[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_new_route got vld=%b dat=%h lst=%b exp vld=0001 dat=5a lst=1",
               bus.m_axi_vld_o, port_dat(0), bus.m_axi_lst_o[0]);
    end
    drive(1'b0, 8'h00, 1'b0, 4'b0000);
    step();
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [5];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
    exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
    rst = 1'b1;
    #3;
    rst = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 8'hE0, 1'b1, 4'b0000);
      step();
      vectors++;
      if (bus.drop_o !== 1'b1 || bus.drop_cnt_o !== exp_cnt[k]) begin
        miscompares++;
        $display("FAIL sat_pkt%0d got drop=%b cnt=%0d exp drop=1 cnt=%0d",
                 k, bus.drop_o, bus.drop_cnt_o, exp_cnt[k]);
      end
    end
    drive(1'b0, 8'h00, 1'b0, 4'b0000);
    step();
    vectors++;
    if (bus.drop_o !== 1'b0 || bus.drop_cnt_o !== 2'd3 || bus.m_axi_vld_o !== 4'b0000) begin
      miscompares++;
      $display("FAIL sat_hold got drop=%b cnt=%0d vld=%b exp drop=0 cnt=3 vld=0000",
               bus.drop_o, bus.drop_cnt_o, bus.m_axi_vld_o);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_route();
    test_select_change();
    test_backpressure();
    bus.m_axi_rdy_i = 4'b1111;
    test_illegal();
    test_reset_mid_packet();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
